// File: rtl/mem_access_unit.sv
// LC-3 data-memory load/store sequencer: one request in flight, LD/LDI/ST/STI with pointer chaining.
// Latency LD 3, LDI 5, ST 2, STI 4 (faults 1 or 3); req_ready only in IDLE, requests never queued.
module mem_access_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [2:0]  req_dst,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic [2:0]  resp_dst,
    output logic        resp_fault,
    output logic        load1Enable,
    output logic [15:0] raddr1,
    input  logic [15:0] rdata1,
    output logic        load2Enable,
    output logic [15:0] raddr2,
    input  logic [15:0] rdata2,
    output logic        writeEnable,
    output logic [15:0] writeAddress,
    output logic [15:0] writeData
);

    typedef enum logic [2:0] {IDLE, RD1, PTR, RD2, WR} state_t;

    localparam logic [1:0]  OP_LDI = 2'b01;
    localparam logic [1:0]  OP_ST  = 2'b10;
    localparam logic [16:0] LIMIT  = 17'(MEM_WORDS);

    function automatic logic out_of_range(input logic [15:0] a);
        return {1'b0, a} >= LIMIT;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] wdata_q, wdata_d;
    logic [2:0]  dst_q, dst_d;
    logic        l1en_q, l1en_d, l2en_q, l2en_d, wen_q, wen_d;
    logic [15:0] raddr1_q, raddr1_d, raddr2_q, raddr2_d;
    logic [15:0] waddr_q, waddr_d, wdat_q, wdat_d;
    logic        rvld_q, rvld_d, rfault_q, rfault_d;
    logic [15:0] rdata_q, rdata_d;
    logic [2:0]  rdst_q, rdst_d;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wdata_d  = wdata_q;
        dst_d    = dst_q;
        l1en_d   = 1'b0;
        l2en_d   = 1'b0;
        wen_d    = 1'b0;
        raddr1_d = raddr1_q;
        raddr2_d = raddr2_q;
        waddr_d  = waddr_q;
        wdat_d   = wdat_q;
        rvld_d   = 1'b0;
        rfault_d = 1'b0;
        rdata_d  = 16'h0;
        rdst_d   = rdst_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    wdata_d = req_wdata;
                    dst_d   = req_dst;
                    if (out_of_range(req_addr)) begin
                        rvld_d   = 1'b1;
                        rfault_d = 1'b1;
                        rdst_d   = req_dst;
                    end else if (req_op == OP_ST) begin
                        wen_d   = 1'b1;
                        waddr_d = req_addr;
                        wdat_d  = req_wdata;
                        state_d = WR;
                    end else begin
                        l1en_d   = 1'b1;
                        raddr1_d = req_addr;
                        state_d  = req_op[0] ? PTR : RD1;
                    end
                end
            end
            // RD1/PTR/RD2 spend the strobe cycle waiting; read data is valid the cycle after.
            RD1: begin
                if (!l1en_q) begin
                    rvld_d  = 1'b1;
                    rdata_d = rdata1;
                    rdst_d  = dst_q;
                    state_d = IDLE;
                end
            end
            PTR: begin
                if (!l1en_q) begin
                    if (out_of_range(rdata1)) begin
                        rvld_d   = 1'b1;
                        rfault_d = 1'b1;
                        rdst_d   = dst_q;
                        state_d  = IDLE;
                    end else if (op_q == OP_LDI) begin
                        l2en_d   = 1'b1;
                        raddr2_d = rdata1;
                        state_d  = RD2;
                    end else begin
                        wen_d   = 1'b1;
                        waddr_d = rdata1;
                        wdat_d  = wdata_q;
                        state_d = WR;
                    end
                end
            end
            RD2: begin
                if (!l2en_q) begin
                    rvld_d  = 1'b1;
                    rdata_d = rdata2;
                    rdst_d  = dst_q;
                    state_d = IDLE;
                end
            end
            WR: begin
                rvld_d  = 1'b1;
                rdst_d  = dst_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            wdata_q  <= 16'h0;
            dst_q    <= 3'h0;
            l1en_q   <= 1'b0;
            l2en_q   <= 1'b0;
            wen_q    <= 1'b0;
            raddr1_q <= 16'h0;
            raddr2_q <= 16'h0;
            waddr_q  <= 16'h0;
            wdat_q   <= 16'h0;
            rvld_q   <= 1'b0;
            rfault_q <= 1'b0;
            rdata_q  <= 16'h0;
            rdst_q   <= 3'h0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            wdata_q  <= wdata_d;
            dst_q    <= dst_d;
            l1en_q   <= l1en_d;
            l2en_q   <= l2en_d;
            wen_q    <= wen_d;
            raddr1_q <= raddr1_d;
            raddr2_q <= raddr2_d;
            waddr_q  <= waddr_d;
            wdat_q   <= wdat_d;
            rvld_q   <= rvld_d;
            rfault_q <= rfault_d;
            rdata_q  <= rdata_d;
            rdst_q   <= rdst_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = rvld_q;
    assign resp_data    = rdata_q;
    assign resp_dst     = rdst_q;
    assign resp_fault   = rfault_q;
    assign load1Enable  = l1en_q;
    assign raddr1       = raddr1_q;
    assign load2Enable  = l2en_q;
    assign raddr2       = raddr2_q;
    assign writeEnable  = wen_q;
    assign writeAddress = waddr_q;
    assign writeData    = wdat_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural data memory, directed requests, response scoreboard.
module tb_mem_access_unit;
    localparam int MW = 1024;
    localparam logic [1:0] LD = 2'b00, LDI = 2'b01, ST = 2'b10, STI = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
    logic [2:0]  req_dst = 3'h0;
    logic        resp_valid, resp_fault;
    logic [15:0] resp_data;
    logic [2:0]  resp_dst;
    logic        load1Enable, load2Enable, writeEnable;
    logic [15:0] raddr1, raddr2, writeAddress, writeData;
    logic [15:0] rdata1 = 16'h0, rdata2 = 16'h0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_dst(req_dst),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_dst(resp_dst),
        .resp_fault(resp_fault),
        .load1Enable(load1Enable), .raddr1(raddr1), .rdata1(rdata1),
        .load2Enable(load2Enable), .raddr2(raddr2), .rdata2(rdata2),
        .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData)
    );

    typedef struct {
        logic [15:0] data;
        logic [2:0]  dst;
        logic        fault;
        int          at;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] mem [0:MW-1];
    int          cyc = 0;
    int          n_checks = 0, n_fail = 0;
    int          wr_pulses = 0, l2_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return (int'(a) < MW) ? mem[a[9:0]] : 16'hDEAD;
    endfunction

    task automatic monitor_step();
        exp_t e;
        if (writeEnable) begin
            wr_pulses++;
            chk("rw_exclusive", 32'(load1Enable | load2Enable), 32'h0);
        end
        if (load2Enable) l2_pulses++;
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid with data %0h, expected none (cycle %0d)",
                         resp_data, cyc);
            end else begin
                e = sbq.pop_front();
                chk("resp_cycle", 32'(cyc), 32'(e.at));
                chk("resp_data", 32'(resp_data), 32'(e.data));
                chk("resp_dst", 32'(resp_dst), 32'(e.dst));
                chk("resp_fault", 32'(resp_fault), 32'(e.fault));
            end
        end
    endtask

    // Returns #1 after the accept edge, i.e. inside cycle c1.
    task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [2:0] dst, input logic [15:0] edata, input logic efault,
                         input int lat);
        int w;
        @(negedge clk);
        req_op = op; req_addr = addr; req_wdata = wd; req_dst = dst; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready stayed 0, expected 1 within 50 cycles");
        end
        sbq.push_back('{edata, dst, efault, cyc + lat});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 16'hFFFF;
        req_wdata = 16'h5A5A;
        req_dst   = 3'h7;
    endtask

    task automatic wait_c(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        #1;
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    endtask

    initial begin
        int w0, l20;
        for (int i = 0; i < MW; i++) mem[i] = 16'h0;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0020] = 16'h0030;
        mem[16'h0030] = 16'h1234;
        mem[16'h0040] = 16'hFFFF;

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            forever begin
                @(posedge clk);
                if (load1Enable) rdata1 <= mem_rd(raddr1);
                if (load2Enable) rdata2 <= mem_rd(raddr2);
                if (writeEnable && int'(writeAddress) < MW) mem[writeAddress[9:0]] <= writeData;
            end
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish, expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        #12;
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_enables", 32'({load1Enable, load2Enable, writeEnable, resp_fault}), 32'h0);
        chk("rst_addrs", {raddr1, raddr2}, 32'h0);
        chk("rst_wr", {writeAddress, writeData}, 32'h0);
        chk("rst_resp", 32'({resp_data, resp_dst}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Direct load
        issue(LD, 16'h0010, 16'h0, 3'd3, 16'hBEEF, 1'b0, 3);
        chk("ld_c1_l1en", 32'(load1Enable), 32'h1);
        chk("ld_c1_raddr1", 32'(raddr1), 32'h0010);

        // Indirect load
        issue(LDI, 16'h0020, 16'h0, 3'd5, 16'h1234, 1'b0, 5);
        wait_c(2);
        chk("ldi_c3_l2en", 32'(load2Enable), 32'h1);
        chk("ldi_c3_raddr2", 32'(raddr2), 32'h0030);
        chk("ldi_c3_l1en", 32'(load1Enable), 32'h0);

        // Indirect store, then read back
        issue(STI, 16'h0020, 16'hA5A5, 3'd1, 16'h0, 1'b0, 4);
        wait_c(2);
        chk("sti_c3_wen", 32'(writeEnable), 32'h1);
        chk("sti_c3_waddr", 32'(writeAddress), 32'h0030);
        chk("sti_c3_wdata", 32'(writeData), 32'hA5A5);
        issue(LD, 16'h0030, 16'h0, 3'd2, 16'hA5A5, 1'b0, 3);

        // Faults: direct out of range, then pointer out of range
        drain();
        w0 = wr_pulses;
        issue(ST, 16'h0400, 16'h7777, 3'd4, 16'h0, 1'b1, 1);
        l20 = l2_pulses;
        issue(LDI, 16'h0040, 16'h0, 3'd6, 16'h0, 1'b1, 3);
        wait_c(4);
        chk("fault_no_write", 32'(wr_pulses), 32'(w0));
        chk("fault_no_load2", 32'(l2_pulses), 32'(l20));
        issue(LD, 16'hFFFF, 16'h0, 3'd0, 16'h0, 1'b1, 1);

        // Back-to-back store then load on the store's response cycle
        issue(ST, 16'h0005, 16'h1111, 3'd0, 16'h0, 1'b0, 2);
        issue(LD, 16'h0005, 16'h0, 3'd7, 16'h1111, 1'b0, 3);
        drain();

        // Reset in the middle of an indirect load
        issue(LDI, 16'h0020, 16'h0, 3'd2, 16'hA5A5, 1'b0, 5);
        wait_c(1);
        rst_n = 1'b0;
        #1;
        chk("abort_enables", 32'({load1Enable, load2Enable, writeEnable, resp_valid}), 32'h0);
        chk("abort_ready", 32'(req_ready), 32'h1);
        void'(sbq.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        wait_c(6);
        chk("post_abort_ready", 32'(req_ready), 32'h1);
        issue(LD, 16'h0010, 16'h0, 3'd4, 16'hBEEF, 1'b0, 3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
